es_mul_rr_scheduler: RTL and testbench
======================================

// Module: es_mul_rr_scheduler
// PURPOSE
//  Shares one es_ordered_mul instance among NUM_REQ requesters.
//  - Round-robin arbitration over the requesters.
//  - Latches the winner's operand vector, clears the multiplier, runs it until done.
//  - Returns the product tagged with the requester ID over a valid/ready response port.
//  - Sits between the requester fabric and the shared multiplier; it is the only
//    driver of the multiplier's rst/en/bin_data_in.
// PARAMETERS
//  DATA_WIDTH     5     operand width per multiplier input
//  NUM_INPUTS     2     operands per multiplication
//  NUM_REQ        4     number of requesters (>=2)
//  OUT_WIDTH      DATA_WIDTH*NUM_INPUTS   product width (matches multiplier output)
//  TIMEOUT_CYCLES 2048  watchdog limit in RUN cycles (used only with ES_SCHED_WATCHDOG_EN)
// PORTS
//  clk          in   1                            clock, single domain
//  rst          in   1                            asynchronous reset, active-high
//  req_valid    in   NUM_REQ                      per-requester operation request
//  req_data     in   NUM_REQ*NUM_INPUTS*DATA_WIDTH  operands; requester r at slice r, input i at sub-slice i
//  req_ready    out  NUM_REQ                      one-hot 1-cycle accept pulse
//  rsp_valid    out  1                            response available
//  rsp_ready    in   1                            response consumed
//  rsp_data     out  OUT_WIDTH                    captured product
//  rsp_id       out  $clog2(NUM_REQ)              requester index of the response
//  rsp_err      out  1                            watchdog abort flag (0 when feature absent)
//  mul_rst      out  1                            registered reset to multiplier
//  mul_en       out  1                            multiplier enable
//  mul_data_in  out  NUM_INPUTS*DATA_WIDTH        latched operands to multiplier
//  mul_data_out in   OUT_WIDTH                    multiplier result
//  mul_done     in   1                            multiplier done (level, held until its reset)
// BEHAVIOUR
//  Reset values (async, rst=1):
//   - state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0
//   - mul_rst=1; mul_en=0; mul_data_in=0; RR pointer=NUM_REQ-1 (requester 0 wins first)
//  All outputs are registered.
//  FSM IDLE -> CLEAR -> RUN -> RESP -> IDLE:
//   IDLE:
//    - mul_rst=1, mul_en=0.
//    - If any req_valid: grant g = first set bit searching from ptr+1 upward with wrap.
//    - Next cycle: req_ready[g]=1 (one cycle only); mul_data_in<=req_data[g]; rsp_id<=g;
//      ptr<=g; go to CLEAR.
//    - No request: stay in IDLE.
//   CLEAR:
//    - Exactly 1 cycle; mul_rst=1, mul_en=0; go to RUN.
//   RUN:
//    - mul_rst=0, mul_en=1.
//    - First cycle mul_done=1: rsp_data<=mul_data_out, rsp_err<=0, mul_en<=0; go to RESP.
//    - mul_done sampled only in RUN; a mul_done high in CLEAR/IDLE is ignored.
//   RESP:
//    - rsp_valid=1; rsp_data/rsp_id/rsp_err held stable while rsp_ready=0.
//    - On rsp_valid&rsp_ready: rsp_valid<=0, mul_rst<=1; go to IDLE.
//    - No new grant is issued while in CLEAR, RUN or RESP (single outstanding op).
//  Latency:
//   - req_valid seen in IDLE -> req_ready pulse: 1 cycle.
//   - req_ready -> mul_en rise: 2 cycles.
//   - mul_done -> rsp_valid: 1 cycle.
//  Requesters must hold req_valid/req_data until their req_ready pulse; dropping
//  req_valid before the grant is legal (request withdrawn).
//  Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.
//  Reset mid-operation: in-flight op is discarded (no response), all outputs return to
//  reset values immediately, ptr=NUM_REQ-1.
// CONFIGURATION
//  ES_SCHED_WATCHDOG_EN defined:
//   - RUN-cycle counter, cleared on entry to RUN.
//   - If it reaches TIMEOUT_CYCLES with mul_done=0: go to RESP with rsp_data=0,
//     rsp_err=1, rsp_id=granted id.
//   - mul_done on the same cycle as the limit wins (normal response).
//  ES_SCHED_WATCHDOG_EN undefined:
//   - No counter; RUN waits indefinitely; rsp_err tied 0; TIMEOUT_CYCLES unused.
// TESTING (defaults, real es_ordered_mul attached unless noted)
//  1 req_valid=4'b0100, operands {3,7} -> req_ready=4'b0100 for 1 cycle, mul_rst 1-cycle
//    CLEAR, rsp_data=21, rsp_id=2, rsp_err=0.
//  2 req_valid=4'b1111 held, operands r:{r+1,2} -> responses in id order 0,1,2,3,0;
//    rsp_data 2,4,6,8.
//  3 rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid/rsp_data/rsp_id stable,
//    req_ready stays 0; release -> IDLE, next grant.
//  4 rst pulsed mid-RUN of id 1 -> no response for id 1; mul_rst=1, mul_en=0,
//    rsp_valid=0; with 4'b0011 pending, next grant is id 0.
//  5 ES_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, stub multiplier with mul_done=0 ->
//    rsp_valid after 16 RUN cycles, rsp_err=1, rsp_data=0.
//  6 Stub multiplier asserts mul_done during CLEAR -> ignored; capture happens only on
//    the first RUN-cycle mul_done.

Source files
------------

// File: rtl/es_mul_rr_scheduler.sv
// Round-robin scheduler sharing one es_ordered_mul among NUM_REQ requesters.
// Optional RUN watchdog enabled by defining ES_SCHED_WATCHDOG_EN.
module es_mul_rr_scheduler #(
  parameter int unsigned DATA_WIDTH     = 5,
  parameter int unsigned NUM_INPUTS     = 2,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned OUT_WIDTH      = DATA_WIDTH * NUM_INPUTS,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [OUT_WIDTH-1:0]                     rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]               rsp_id,
  output logic                                     rsp_err,
  output logic                                     mul_rst,
  output logic                                     mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]         mul_data_in,
  input  logic [OUT_WIDTH-1:0]                     mul_data_out,
  input  logic                                     mul_done
);

  localparam int unsigned OP_W = NUM_INPUTS * DATA_WIDTH;
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 mul_rst_q, mul_rst_d;
  logic                 mul_en_q, mul_en_d;
  logic [OP_W-1:0]      mul_data_q, mul_data_d;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      cand;
  logic                 wd_expire;

  // Round-robin search starting just above the last winner, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

`ifdef ES_SCHED_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q;

  // Counts RUN cycles; held at zero outside RUN so every RUN entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == RUN) begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign wd_expire = (state_q == RUN) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT_CYCLES));
  assign wd_expire      = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    mul_rst_d   = mul_rst_q;
    mul_en_d    = mul_en_q;
    mul_data_d  = mul_data_q;

    case (state_q)
      IDLE: begin
        mul_rst_d = 1'b1;
        mul_en_d  = 1'b0;
        if (grant_vld) begin
          req_ready_d = NUM_REQ'(1) << grant_id;
          mul_data_d  = req_data[grant_id*OP_W +: OP_W];
          rsp_id_d    = grant_id;
          ptr_d       = grant_id;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        mul_rst_d = 1'b1;
        mul_en_d  = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        mul_rst_d = 1'b0;
        mul_en_d  = 1'b1;
        // A done on the limit cycle takes priority over the abort.
        if (mul_done) begin
          rsp_data_d  = mul_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          mul_en_d    = 1'b0;
          state_d     = RESP;
        end else if (wd_expire) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          mul_en_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        mul_en_d    = 1'b0;
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          mul_rst_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      mul_rst_q   <= 1'b1;
      mul_en_q    <= 1'b0;
      mul_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      mul_rst_q   <= mul_rst_d;
      mul_en_q    <= mul_en_d;
      mul_data_q  <= mul_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_err     = rsp_err_q;
  assign mul_rst     = mul_rst_q;
  assign mul_en      = mul_en_q;
  assign mul_data_in = mul_data_q;

endmodule

// File: tb/tb_es_mul_rr_scheduler.sv
// Bench for es_mul_rr_scheduler with a behavioural multiplier and a response scoreboard.
module tb_es_mul_rr_scheduler;

  localparam int unsigned DW  = 5;
  localparam int unsigned NI  = 2;
  localparam int unsigned NR  = 4;
  localparam int unsigned OW  = DW * NI;
  localparam int unsigned OPW = DW * NI;
`ifdef ES_SCHED_WATCHDOG_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 2048;
`endif

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*OPW-1:0] req_data;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OW-1:0]     rsp_data;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic              mul_rst;
  logic              mul_en;
  logic [OPW-1:0]    mul_data_in;
  logic [OW-1:0]     mul_data_out;
  logic              mul_done;

  es_mul_rr_scheduler #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_data_in(mul_data_in),
    .mul_data_out(mul_data_out), .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: product ready 3 enabled cycles after leaving reset.
  logic [1:0]  m_cnt;
  logic        m_done;
  logic [9:0]  m_out;
  logic        stall;
  logic        glitch_en;
  logic        glitch;

  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt  <= 2'd0;
      m_done <= 1'b0;
      m_out  <= 10'd0;
    end else if (mul_en && !m_done && !stall) begin
      if (m_cnt == 2'd2) begin
        m_done <= 1'b1;
        m_out  <= 10'(mul_data_in[4:0] * mul_data_in[9:5]);
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  assign glitch       = glitch_en && (req_ready != '0);
  assign mul_done     = m_done | glitch;
  assign mul_data_out = glitch ? 10'h3FF : m_out;

  typedef struct packed {
    logic       err;
    logic [1:0] id;
    logic [9:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_err_id_data", 32'({rsp_err, rsp_id, rsp_data}), 32'(mon_e));
        end
      end
    end
  end

  task automatic set_req(input int r, input int a, input int b);
    req_data[r*OPW +: OPW] = {5'(b), 5'(a)};
  endtask

  task automatic push_exp(input logic err, input int id, input int data);
    exp_t e;
    e.err  = err;
    e.id   = 2'(id);
    e.data = 10'(data);
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int budget, output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < budget && g == '0; i++) begin
      @(negedge clk);
      g = req_ready;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || rsp_valid); i++) @(negedge clk);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [NR-1:0] g;
    int            cyc;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    stall     = 1'b0;
    glitch_en = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_err, mul_rst, mul_en}),
          32'({4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0}));
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_mul_data_in", 32'(mul_data_in), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request from id 2, operands 3 and 7
    @(negedge clk);
    set_req(2, 3, 7);
    req_valid = 4'b0100;
    push_exp(1'b0, 2, 21);
    wait_grant(20, g);
    check("t1_grant", 32'(g), 32'(4'b0100));
    check("t1_grant_state", 32'({rsp_id, mul_rst, mul_en}), 32'({2'd2, 1'b1, 1'b0}));
    check("t1_mul_data_in", 32'(mul_data_in), 32'({5'd7, 5'd3}));
    req_valid = '0;
    @(negedge clk);
    check("t1_clear", 32'({req_ready, mul_rst, mul_en}), 32'({4'b0000, 1'b1, 1'b0}));
    @(negedge clk);
    check("t1_run_enable", 32'({mul_rst, mul_en}), 32'({1'b0, 1'b1}));
    drain(50);

    // All four requesting from a fresh reset: ids 0,1,2,3,0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 4; r++) set_req(r, r + 1, 2);
    for (int k = 0; k < 5; k++) push_exp(1'b0, k % 4, 2 * ((k % 4) + 1));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(50, g);
      check("t2_rr_grant", 32'(g), 32'(4'b0001 << (k % 4)));
    end
    req_valid = '0;
    drain(80);

    // Back-pressure: response held stable and no new grant while stalled
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    set_req(1, 5, 6);
    set_req(3, 4, 4);
    push_exp(1'b0, 1, 30);
    push_exp(1'b0, 3, 16);
    req_valid = 4'b0010;
    wait_grant(20, g);
    check("t3_grant_id1", 32'(g), 32'(4'b0010));
    req_valid = 4'b1000;
    for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_stall_hold", 32'({rsp_valid, req_ready, rsp_err, rsp_id, rsp_data}),
            32'({1'b1, 4'b0000, 1'b0, 2'd1, 10'd30}));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_grant(20, g);
    check("t3_next_grant", 32'(g), 32'(4'b1000));
    req_valid = '0;
    drain(50);

    // Reset in the middle of RUN for id 1
    stall = 1'b1;
    @(negedge clk);
    set_req(1, 7, 7);
    req_valid = 4'b0010;
    wait_grant(20, g);
    check("t4_grant_id1", 32'(g), 32'(4'b0010));
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("t4_in_run", 32'({mul_rst, mul_en, rsp_valid}), 32'({1'b0, 1'b1, 1'b0}));
    @(posedge clk); #1 rst = 1'b1;
    #1 check("t4_async_reset", 32'({mul_rst, mul_en, rsp_valid, req_ready, rsp_id}),
             32'({1'b1, 1'b0, 1'b0, 4'b0000, 2'd0}));
    stall = 1'b0;
    set_req(0, 2, 3);
    req_valid = 4'b0011;
    push_exp(1'b0, 0, 6);
    push_exp(1'b0, 1, 49);
    @(posedge clk); #1 rst = 1'b0;
    wait_grant(20, g);
    check("t4_grant_after_reset", 32'(g), 32'(4'b0001));
    req_valid = 4'b0010;
    wait_grant(50, g);
    check("t4_grant_id1_again", 32'(g), 32'(4'b0010));
    req_valid = '0;
    drain(50);

    // Spurious done while clearing must not be captured
    glitch_en = 1'b1;
    @(negedge clk);
    set_req(2, 9, 3);
    req_valid = 4'b0100;
    push_exp(1'b0, 2, 27);
    wait_grant(20, g);
    check("t6_grant", 32'(g), 32'(4'b0100));
    req_valid = '0;
    drain(50);
    glitch_en = 1'b0;

`ifdef ES_SCHED_WATCHDOG_EN
    // Watchdog abort after TMO RUN cycles with a stuck multiplier
    stall = 1'b1;
    @(negedge clk);
    set_req(0, 3, 3);
    req_valid = 4'b0001;
    push_exp(1'b1, 0, 0);
    wait_grant(20, g);
    check("t5_grant", 32'(g), 32'(4'b0001));
    req_valid = '0;
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_timeout_latency", 32'(cyc), 32'(TMO + 1));
    drain(20);
    stall = 1'b0;
`else
    cyc = 0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

endmodule
